mix_columns_iter: RTL and testbench
===================================

// Module: mix_columns_iter
// PURPOSE
//  Iterative, handshaked AES MixColumns / InvMixColumns engine for the round datapath.
//  Processes COLS_PER_CYCLE 32-bit columns per clock; direction is selected per block.
//  Successor to the purely combinational inverse-only MixColumns, for area/timing tradeoff in round loops.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal 1, 2, 4 (other values: $error at elaboration)
//  OUT_REG         1  1 = state_out driven from a register; 0 = same register, no extra stage (kept for future)
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    synchronous, active-high reset
//  in_valid   in   1    state_in/inv valid
//  in_ready   out  1    engine can accept a block
//  inv        in   1    0 = MixColumns, 1 = InvMixColumns; sampled at accept
//  state_in   in   128  input state; column c = [127-32c -: 32], row r byte = [127-32c-8r -: 8]
//  out_valid  out  1    state_out valid
//  out_ready  in   1    downstream accepts state_out
//  state_out  out  128  transformed state, same byte layout
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=0 during reset cycle, 1 first cycle after; out_valid=0, busy=0, state_out=0.
//  - FSM: IDLE --(in_valid&in_ready)--> RUN --(last column group done)--> DONE --(out_ready)--> IDLE.
//  - in_ready = (state==IDLE). At accept: state_in -> work reg, inv -> mode reg, column counter=0.
//  - RUN: each cycle columns [cnt*CPC .. cnt*CPC+CPC-1] replaced in work reg; cnt += 1;
//    N = 4/COLS_PER_CYCLE RUN cycles; cnt wraps to 0 on entering DONE.
//  - Latency: accept edge to out_valid high = N+1 edges (CPC=4: 2, CPC=1: 5). Throughput 1 block per N+2 cycles
//    with out_ready held high.
//  - DONE: out_valid=1, state_out = work reg, held stable while out_ready=0 (no change on state_out/out_valid).
//    On out_ready, next cycle IDLE; no new accept in the same cycle as output handoff.
//  - Arithmetic per column a0..a3 (GF(2^8), poly 0x11b, xtime(x) = x<<1 ^ (x[7]?0x1b:0)):
//    fwd: b_r = 02*a_r ^ 03*a_{r+1} ^ a_{r+2} ^ a_{r+3}; inv: b_r = 0e*a_r ^ 0b*a_{r+1} ^ 0d*a_{r+2} ^ 09*a_{r+3}
//    (indices mod 4). All products built from xtime chains; no lookup tables; 8-bit results, no carries.
//  - inv/state_in changes while not IDLE are ignored. in_valid without in_ready has no effect.
//  - reset asserted in any state (incl. mid-RUN or DONE stalled): abort, return to reset values next edge.
// CONFIGURATION
//  MIXCOL_BYPASS_EN defined: extra input port `bypass` (1 bit, sampled at accept with inv). bypass=1:
//    RUN is skipped, IDLE -> DONE directly, state_out = state_in unchanged (AES final round); latency 1 edge.
//  MIXCOL_BYPASS_EN undefined: no bypass port; every block goes through RUN.
// TESTING
//  - Fwd, CPC=4: state_in=128'hdb135345_f20a225c_01010101_c6c6c6c6, inv=0
//    -> state_out=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 2 edges after accept.
//  - Inv, CPC=1: state_in=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv=1 -> state_out=128'hdb135345_f20a225c_01010101_c6c6c6c6,
//    out_valid 5 edges after accept; in_ready=0 throughout RUN/DONE.
//  - Backpressure: out_ready=0 for 10 cycles in DONE -> state_out/out_valid stable; out_ready=1 -> IDLE, in_ready=1 next cycle.
//  - Reset mid-RUN (CPC=1, 2nd RUN cycle) -> next edge out_valid=0, busy=0, state_out=0; in_ready=1 once reset drops.
//  - Round trip, 1000 random states, all CPC values: fwd then inv -> equals original; in_valid toggled randomly.
//  - MIXCOL_BYPASS_EN: bypass=1, state_in=128'h00112233_44556677_8899aabb_ccddeeff -> identical state_out, 1 edge latency.

Source files
------------

// File: rtl/mix_columns_iter.sv
// Iterative handshaked AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional `define MIXCOL_BYPASS_EN adds a `bypass` input that passes the state through unchanged.
module mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1,
    parameter bit          OUT_REG        = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
`ifdef MIXCOL_BYPASS_EN
    input  logic         bypass,
`endif
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int Cpc = int'(COLS_PER_CYCLE);
    localparam int NumGrp = (Cpc == 0) ? 4 : 4 / Cpc;
    localparam logic [1:0] LastGrp = 2'(NumGrp - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           mode_q, mode_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   out_q, out_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    logic [31:0]    col_in  [Cpc];
    logic [31:0]    col_out [Cpc];
    logic [127:0]   mixed;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_m);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m2 [4];
        logic [7:0] m3 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31 - 8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m2[r] = x2[r];
            m3[r] = x2[r] ^ a[r];
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        for (int r = 0; r < 4; r++) begin
            if (inv_m) begin
                res[31 - 8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
            end else begin
                res[31 - 8*r -: 8] = m2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return res;
    endfunction

    // Only the current column group is routed through the Cpc mixing units.
    always_comb begin
        mixed = work_q;
        for (int g = 0; g < Cpc; g++) begin
            col_in[g]  = work_q[127 - 32*(int'(cnt_q)*Cpc + g) -: 32];
            col_out[g] = mix_col(col_in[g], mode_q);
        end
        for (int c = 0; c < 4; c++) begin
            if (c / Cpc == int'(cnt_q)) begin
                mixed[127 - 32*c -: 32] = col_out[c % Cpc];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        out_d   = out_q;
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    work_d = state_in;
                    mode_d = inv;
                    cnt_d  = '0;
`ifdef MIXCOL_BYPASS_EN
                    if (bypass) begin
                        state_d = StDone;
                        out_d   = state_in;
                    end else begin
                        state_d = StRun;
                    end
`else
                    state_d = StRun;
`endif
                end
            end
            StRun: begin
                work_d = mixed;
                if (cnt_q == LastGrp) begin
                    cnt_d   = '0;
                    state_d = StDone;
                    out_d   = mixed;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            work_q      <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            work_q      <= work_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Both sources hold the same value while out_valid is high.
    assign state_out = OUT_REG ? out_q : work_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter: one instance per COLS_PER_CYCLE (1, 2, 4).
// Exercises the bypass path when MIXCOL_BYPASS_EN is defined.
module tb_mix_columns_iter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mc_model(input logic [127:0] s, input logic m);
        logic [7:0]   k [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (m) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   k = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(k[j], s[127 - 32*c - 8*((r+j)%4) -: 8]);
                end
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int C = 1 << gi;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic         inv = 1'b0;
        logic [127:0] state_in = '0;
        logic         out_valid;
        logic         out_ready = 1'b1;
        logic [127:0] state_out;
        logic         busy;
`ifdef MIXCOL_BYPASS_EN
        logic         bypass = 1'b0;
`endif
        logic [127:0] exp_q [$];

        mix_columns_iter #(
            .COLS_PER_CYCLE(C),
            .OUT_REG       (1'b1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .inv      (inv),
`ifdef MIXCOL_BYPASS_EN
            .bypass   (bypass),
`endif
            .state_in (state_in),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .state_out(state_out),
            .busy     (busy)
        );

        always @(negedge clk) begin
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out cpc=%0d: got %h want no output", C, state_out);
                end else begin
                    chk($sformatf("out_cpc%0d", C), state_out, exp_q.pop_front());
                end
            end
        end

        // Returns just after the accepting edge (or after a failed bounded wait).
        task automatic send(input logic [127:0] d, input logic m, input logic b,
                            input logic [127:0] e, input bit push);
            int n = 0;
            @(negedge clk);
            state_in = d;
            inv      = m;
            in_valid = 1'b1;
`ifdef MIXCOL_BYPASS_EN
            bypass   = b;
`endif
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL accept_timeout cpc=%0d: got in_ready=0 want 1", C);
            end else begin
                if (push) exp_q.push_back(e);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        endtask

        task automatic wait_out(output int edges);
            edges = 1;
            while (!out_valid && edges < 50) begin
                @(posedge clk);
                #1;
                edges++;
            end
        endtask

        task automatic chk_quiet(input string tag, input logic rdy);
            chk({tag, "_in_ready"}, 128'(in_ready), 128'(rdy));
            chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
            chk({tag, "_busy"}, 128'(busy), 128'd0);
            chk({tag, "_state_out"}, state_out, 128'd0);
        endtask

        task automatic drain();
            int n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                @(posedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain cpc=%0d: got %0d pending want 0", C, exp_q.size());
            end
        endtask

        task automatic round_trip(input int count);
            logic [127:0] x;
            for (int i = 0; i < count; i++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(x, 1'b0, 1'b0, mc_model(x, 1'b0), 1'b1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(mc_model(x, 1'b0), 1'b1, 1'b0, x, 1'b1);
            end
        endtask
    end

    localparam logic [127:0] VecA = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VecB = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FipsIn  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FipsOut = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    initial begin
        int edges;
        repeat (2) @(posedge clk);
        #1;
        g_dut[0].chk_quiet("rst0", 1'b0);
        g_dut[1].chk_quiet("rst1", 1'b0);
        g_dut[2].chk_quiet("rst2", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        g_dut[0].chk_quiet("post_rst0", 1'b1);
        g_dut[1].chk_quiet("post_rst1", 1'b1);
        g_dut[2].chk_quiet("post_rst2", 1'b1);

        // CPC=4 forward, 2 edges including the accepting one.
        g_dut[2].send(VecA, 1'b0, 1'b0, VecB, 1'b1);
        g_dut[2].wait_out(edges);
        chk("lat_cpc4", 128'(edges), 128'd2);
        g_dut[2].send(VecB, 1'b1, 1'b0, VecA, 1'b1);

        // CPC=1 inverse with junk held on the input side while busy.
        g_dut[0].send(VecB, 1'b1, 1'b0, VecA, 1'b1);
        g_dut[0].state_in = '1;
        g_dut[0].inv      = 1'b0;
        g_dut[0].in_valid = 1'b1;
        edges = 1;
        while (!g_dut[0].out_valid && edges < 20) begin
            chk("rdy_run_cpc1", 128'(g_dut[0].in_ready), 128'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        g_dut[0].in_valid = 1'b0;
        chk("rdy_done_cpc1", 128'(g_dut[0].in_ready), 128'd0);
        chk("lat_cpc1", 128'(edges), 128'd5);
        g_dut[0].send(VecA, 1'b0, 1'b0, VecB, 1'b1);

        // CPC=2 backpressure in DONE.
        g_dut[1].out_ready = 1'b0;
        g_dut[1].send(FipsIn, 1'b0, 1'b0, FipsOut, 1'b1);
        g_dut[1].wait_out(edges);
        chk("lat_cpc2", 128'(edges), 128'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 128'(g_dut[1].out_valid), 128'd1);
            chk("bp_data", g_dut[1].state_out, FipsOut);
            chk("bp_rdy", 128'(g_dut[1].in_ready), 128'd0);
        end
        g_dut[1].out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_rdy", 128'(g_dut[1].in_ready), 128'd1);
        chk("bp_release_valid", 128'(g_dut[1].out_valid), 128'd0);
        g_dut[1].send(FipsOut, 1'b1, 1'b0, FipsIn, 1'b1);
        g_dut[0].drain();
        g_dut[1].drain();
        g_dut[2].drain();

        // Reset during the second RUN cycle of CPC=1 aborts the block.
        g_dut[0].send(FipsIn, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_run_busy", 128'(g_dut[0].busy), 128'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        g_dut[0].chk_quiet("mid_rst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        g_dut[0].chk_quiet("mid_rst_rel", 1'b1);

`ifdef MIXCOL_BYPASS_EN
        g_dut[2].send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1,
                      128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
        g_dut[2].wait_out(edges);
        chk("lat_bypass_cpc4", 128'(edges), 128'd1);
        g_dut[0].send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1,
                      128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
        g_dut[0].wait_out(edges);
        chk("lat_bypass_cpc1", 128'(edges), 128'd1);
        g_dut[0].drain();
        g_dut[2].drain();
`endif

        fork
            g_dut[0].round_trip(1000);
            g_dut[1].round_trip(1000);
            g_dut[2].round_trip(1000);
        join
        g_dut[0].drain();
        g_dut[1].drain();
        g_dut[2].drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
